conv_p: RTL and testbench

CONV_P -- requirements
Module: conv_p

---
 rtl/conv_p_pkg.sv | 44 ++++
 rtl/conv_p_mac.sv | 44 ++++
 rtl/conv_p.sv | 183 ++++++++++++++++++
 tb/tb_conv_p.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/conv_p_pkg.sv
// Shared types and constants for the conv_p 3x3 convolution / 2x2 max-pool engine.
package conv_p_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_WR0,
    S_POOL,
    S_WR1,
    S_DONE
  } state_t;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam int         NUM_COEF = 10;
  localparam logic [3:0] BIAS_IDX = 4'd9;

  // Reset coefficients in Q4.16: index 9 is the bias, 0..8 are K0..K8 in raster order.
  localparam logic [NUM_COEF-1:0][19:0] COEF_DEF = {
    20'h01310,
    20'hFAC19, 20'hFC834, 20'hFA6D7,
    20'hF6E54, 20'hF8F71, 20'h01004,
    20'h06D43, 20'h092D5, 20'h0A89E
  };

  // Tap k -> {row offset, col offset}, each 0..2 (k/3, k%3).
  function automatic logic [3:0] tap_offs(input logic [3:0] k);
    case (k)
      4'd0:    tap_offs = 4'b00_00;
      4'd1:    tap_offs = 4'b00_01;
      4'd2:    tap_offs = 4'b00_10;
      4'd3:    tap_offs = 4'b01_00;
      4'd4:    tap_offs = 4'b01_01;
      4'd5:    tap_offs = 4'b01_10;
      4'd6:    tap_offs = 4'b10_00;
      4'd7:    tap_offs = 4'b10_01;
      4'd8:    tap_offs = 4'b10_10;
      default: tap_offs = 4'b00_00;
    endcase
  endfunction

endpackage

// File: rtl/conv_p_mac.sv
// Signed multiply-accumulate plus round / ReLU / saturate output stage.
module conv_p_mac #(
  parameter int DW   = 20,
  parameter int FRAC = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] pix,
  input  logic [DW-1:0] wgt,
  input  logic [DW-1:0] bias,
  input  logic          relu,
  output logic [DW-1:0] res
);
  localparam int AW = 2*DW + 4;
  localparam int SW = AW + 2;
  localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [AW-1:0]   acc;
  logic signed [2*DW-1:0] prod;
  logic signed [SW-1:0]   sum, rnd;

  assign prod = $signed(pix) * $signed(wgt);

  // Accumulator: cleared at the first step of each pixel, adds in-bounds taps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + AW'(prod);
  end

  // Add bias and half-LSB, drop fraction, optional ReLU, clamp to DW bits.
  always_comb begin
    sum = SW'(acc) + (SW'($signed(bias)) <<< FRAC) + (SW'(1) <<< (FRAC-1));
    rnd = sum >>> FRAC;
    if (relu && rnd < 0) rnd = '0;
    if (rnd > SMAX)      res = SMAX[DW-1:0];
    else if (rnd < SMIN) res = SMIN[DW-1:0];
    else                 res = rnd[DW-1:0];
  end

endmodule

// File: rtl/conv_p.sv
// conv_p: 3x3 convolution (L0) with optional 2x2 max-pool (L1) over an N x N image.
module conv_p
  import conv_p_pkg::*;
#(
  parameter int IMG_LOG2 = 6,
  parameter int DW       = 20,
  parameter int FRAC     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  input  logic                  relu_en,
  input  logic                  pool_en,
  input  logic                  kw_en,
  input  logic [3:0]            kw_idx,
  input  logic [DW-1:0]         kw_data,
  output logic                  busy,
  output logic [2*IMG_LOG2-1:0] iaddr,
  input  logic [DW-1:0]         idata,
  output logic                  cwr,
  output logic [2*IMG_LOG2-1:0] caddr_wr,
  output logic [DW-1:0]         cdata_wr,
  output logic                  crd,
  output logic [2*IMG_LOG2-1:0] caddr_rd,
  input  logic [DW-1:0]         cdata_rd,
  output logic [2:0]            csel
);
  localparam int L  = IMG_LOG2;
  localparam int AW = 2*L;
  localparam int N  = 1 << L;
  localparam logic [AW-1:0] L0_LAST = '1;
  localparam logic [AW-1:0] L1_LAST = AW'((N*N/4) - 1);

  state_t                     state_q, state_d;
  logic [3:0]                 step, wsel;
  logic [AW-1:0]              pix;
  logic                       relu_q, pool_q;
  logic [NUM_COEF-1:0][DW-1:0] coef;
  logic                       tap_ok, tap_ok_q;
  logic [1:0]                 dr, dc;
  logic [L+1:0]               tr, tc, trm, tcm;
  logic signed [DW-1:0]       mx;
  logic [DW-1:0]              mac_res;
  logic                       mac_clr, mac_en;

  // Tap position for the current step; rows/cols are offset by +1 so bounds are 1..N.
  always_comb begin
    {dr, dc} = tap_offs(step);
    tr       = {2'b00, pix[AW-1:L]} + {{L{1'b0}}, dr};
    tc       = {2'b00, pix[L-1:0]}  + {{L{1'b0}}, dc};
    trm      = tr - (L+2)'(1);
    tcm      = tc - (L+2)'(1);
    tap_ok   = (tr != '0) && (tr <= (L+2)'(N)) && (tc != '0) && (tc <= (L+2)'(N));
  end

  assign wsel    = (step == 4'd0) ? 4'd0 : step - 4'd1;
  assign mac_clr = (state_q == S_CONV) && (step == 4'd0);
  assign mac_en  = (state_q == S_CONV) && (step != 4'd0) && tap_ok_q;

  conv_p_mac #(.DW(DW), .FRAC(FRAC)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .pix   (idata),
    .wgt   (coef[wsel]),
    .bias  (coef[BIAS_IDX]),
    .relu  (relu_q),
    .res   (mac_res)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and all memory-side outputs, decoded from state and step.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    cwr      = 1'b0;
    crd      = 1'b0;
    csel     = CSEL_NONE;
    iaddr    = '0;
    caddr_wr = '0;
    caddr_rd = '0;
    cdata_wr = '0;
    case (state_q)
      S_IDLE: if (ready) begin
        state_d = S_CONV;
        busy    = reset;
      end
      S_CONV: begin
        busy = 1'b1;
        if (step <= 4'd8) iaddr = {trm[L-1:0], tcm[L-1:0]};
        if (step == 4'd9) state_d = S_WR0;
      end
      S_WR0: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = CSEL_L0;
        caddr_wr = pix;
        cdata_wr = mac_res;
        if (pix == L0_LAST) state_d = pool_q ? S_POOL : S_DONE;
        else                state_d = S_CONV;
      end
      S_POOL: begin
        busy = 1'b1;
        if (step <= 4'd3) begin
          crd      = 1'b1;
          csel     = CSEL_L0;
          caddr_rd = {pix[AW-3:L-1], step[1], pix[L-2:0], step[0]};
        end
        if (step == 4'd4) state_d = S_WR1;
      end
      S_WR1: begin
        busy     = 1'b1;
        cwr      = 1'b1;
        csel     = CSEL_L1;
        caddr_wr = pix;
        cdata_wr = mx;
        state_d  = (pix == L1_LAST) ? S_DONE : S_POOL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Step / pixel counters and mode latch; pix is reused as the L1 index during pooling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step   <= '0;
      pix    <= '0;
      relu_q <= 1'b0;
      pool_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          step <= '0;
          pix  <= '0;
          if (ready) begin
            relu_q <= relu_en;
            pool_q <= pool_en;
          end
        end
        S_CONV, S_POOL: step <= step + 4'd1;
        S_WR0, S_WR1: begin
          step <= '0;
          pix  <= pix + AW'(1);
        end
        default: begin
          step <= '0;
          pix  <= '0;
        end
      endcase
    end
  end

  // Tap validity follows idata by one cycle; running signed max over the 4 pool reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_ok_q <= 1'b0;
      mx       <= '0;
    end else begin
      tap_ok_q <= (state_q == S_CONV) && (step <= 4'd8) && tap_ok;
      if (state_q == S_POOL) begin
        if (step == 4'd1) mx <= $signed(cdata_rd);
        else if (step >= 4'd2 && step <= 4'd4 && $signed(cdata_rd) > mx) mx <= $signed(cdata_rd);
      end
    end
  end

  // Coefficient file: host-writable only while idle, defaults on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_COEF; i++) coef[i] <= DW'($signed(COEF_DEF[i]));
    end else if (kw_en && !busy && kw_idx <= BIAS_IDX) begin
      coef[kw_idx] <= kw_data;
    end
  end

endmodule

// File: tb/tb_conv_p.sv
// Scoreboard bench for conv_p at IMG_LOG2=2 (4x4 image), DW=20, FRAC=16.
module tb_conv_p;
  localparam int L  = 2;
  localparam int N  = 4;
  localparam int DW = 20;
  localparam int AW = 2*L;

  typedef struct packed {
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  // Hand-computed L0 results: default coefficients, all pixels 1.0, ReLU on.
  localparam logic [DW-1:0] DEF_EXP [16] = '{
    20'h00000, 20'h00000, 20'h00000, 20'h00000,
    20'h00000, 20'h00000, 20'h00000, 20'h05D03,
    20'h00000, 20'h00000, 20'h00000, 20'h05D03,
    20'h010ED, 20'h0C98F, 20'h0C98F, 20'h0EDF8
  };

  logic          clk = 1'b0, reset = 1'b0, ready = 1'b0;
  logic          relu_en = 1'b0, pool_en = 1'b0, kw_en = 1'b0;
  logic [3:0]    kw_idx = '0;
  logic [DW-1:0] kw_data = '0;
  logic          busy, cwr, crd;
  logic [2:0]    csel;
  logic [AW-1:0] iaddr, caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr;
  logic [DW-1:0] idata = '0, cdata_rd = '0;

  logic [DW-1:0] img [16];
  logic [DW-1:0] l0m [16];
  wr_t           exp_q [$];
  int            n_chk = 0, n_pass = 0, proto_err = 0;

  conv_p #(.IMG_LOG2(L), .DW(DW), .FRAC(16)) dut (
    .clk(clk), .reset(reset), .ready(ready), .relu_en(relu_en), .pool_en(pool_en),
    .kw_en(kw_en), .kw_idx(kw_idx), .kw_data(kw_data), .busy(busy), .iaddr(iaddr),
    .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
    .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
  );

  always #5 clk = ~clk;

  // Image ROM and L0 result RAM, both with one-cycle read latency.
  always @(posedge clk) begin
    idata <= img[iaddr];
    if (crd) cdata_rd <= l0m[caddr_rd];
    if (cwr && csel == 3'b001) l0m[caddr_wr] <= cdata_wr;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe is matched against the head of the expectation queue.
  always @(negedge clk) begin : mon
    wr_t e;
    if (cwr === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got sel=%b addr=%0d data=0x%0h, want none", csel, caddr_wr, cdata_wr);
      end else begin
        e = exp_q.pop_front();
        check("write", {csel, caddr_wr, cdata_wr}, e);
      end
    end
    if (cwr === 1'b1 && crd === 1'b1) proto_err++;
  end

  task automatic push(input logic [2:0] s, input int a, input logic [DW-1:0] d);
    exp_q.push_back(wr_t'{sel: s, addr: AW'(a), data: d});
  endtask

  task automatic set_coef(input int idx, input logic [DW-1:0] v);
    @(posedge clk); #1 kw_en = 1'b1; kw_idx = 4'(idx); kw_data = v;
    @(posedge clk); #1 kw_en = 1'b0;
  endtask

  task automatic fill_const(input logic [DW-1:0] v);
    for (int a = 0; a < 16; a++) img[a] = v;
  endtask

  task automatic fill_ident();
    for (int a = 0; a < 16; a++) img[a] = DW'(a) << 16;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cwr"}, cwr, 0);
    check({tag, "_crd"}, crd, 0);
    check({tag, "_csel"}, csel, 0);
    check({tag, "_iaddr"}, iaddr, 0);
    check({tag, "_caddr_wr"}, caddr_wr, 0);
    check({tag, "_caddr_rd"}, caddr_rd, 0);
    check({tag, "_cdata_wr"}, cdata_wr, 0);
  endtask

  // Start a frame, optionally poke kw_en/ready mid-frame, count busy cycles until DONE.
  task automatic run_frame(input logic relu, input logic pool, input int exp_busy, input logic poke);
    int bcnt;
    bit done;
    @(posedge clk); #1 relu_en = relu; pool_en = pool; ready = 1'b1;
    @(negedge clk); bcnt = busy ? 1 : 0;
    @(posedge clk); #1 ready = 1'b0; relu_en = 1'b0; pool_en = 1'b0;
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (poke && cyc == 5) begin kw_en = 1'b1; kw_idx = 4'd0; kw_data = 20'h10000; ready = 1'b1; end
      if (poke && cyc == 6) begin kw_en = 1'b0; ready = 1'b0; end
      if (busy) bcnt++;
      else done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL frame_timeout: busy still high after 3000 cycles, want low");
    end
    check("busy_cycles", bcnt, exp_busy);
    check("writes_outstanding", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    #3 check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Default coefficients, all 1.0, ReLU on: 16 writes, busy 176+1.
    fill_const(20'h10000);
    for (int a = 0; a < 16; a++) push(3'b001, a, DEF_EXP[a]);
    run_frame(1'b1, 1'b0, 177, 1'b0);

    // Identity kernel with pooling: L0 copies input, L1 picks block maxima.
    for (int i = 0; i < 10; i++) set_coef(i, '0);
    set_coef(4, 20'h10000);
    fill_ident();
    for (int a = 0; a < 16; a++) push(3'b001, a, DW'(a) << 16);
    push(3'b011, 0, 20'h50000);
    push(3'b011, 1, 20'h70000);
    push(3'b011, 2, 20'hD0000);
    push(3'b011, 3, 20'hF0000);
    run_frame(1'b0, 1'b1, 201, 1'b0);

    // -1.0 * 2.0 = -2.0 without ReLU, clamped to 0 with ReLU.
    set_coef(4, 20'hF0000);
    fill_const(20'h20000);
    for (int a = 0; a < 16; a++) push(3'b001, a, 20'hE0000);
    run_frame(1'b0, 1'b0, 177, 1'b0);
    for (int a = 0; a < 16; a++) push(3'b001, a, 20'h00000);
    run_frame(1'b1, 1'b0, 177, 1'b0);

    // Positive overflow saturates to the largest DW-bit value.
    set_coef(4, 20'h7FFFF);
    fill_const(20'h7FFFF);
    for (int a = 0; a < 16; a++) push(3'b001, a, 20'h7FFFF);
    run_frame(1'b0, 1'b0, 177, 1'b0);

    // kw_en and ready during busy are ignored: K0 stays 0, no restart.
    set_coef(4, 20'h10000);
    fill_ident();
    for (int a = 0; a < 16; a++) push(3'b001, a, DW'(a) << 16);
    run_frame(1'b0, 1'b0, 177, 1'b1);

    // Reset mid-frame: outputs drop at once, coefficients return to defaults.
    for (int a = 0; a < 16; a++) push(3'b001, a, DW'(a) << 16);
    @(posedge clk); #1 ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    repeat (48) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_idle_outputs("midreset");
    check("midreset_writes_done", exp_q.size(), 12);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    fill_const(20'h10000);
    for (int a = 0; a < 16; a++) push(3'b001, a, DEF_EXP[a]);
    run_frame(1'b1, 1'b0, 177, 1'b0);

    check("cwr_crd_overlap", proto_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
